spi_xfer_ctrl: RTL and testbench

SPI master transfer sequencer sitting between the TX and RX sync FIFOs and the SPI pins.
- Pops bytes from the TX FIFO read side and shifts each out MSB-first (SPI mode 0).
- Captures MISO into a byte and pushes it into the RX FIFO write side.
- Runs a software-programmed byte count per transaction, with back-pressure from both FIFOs.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_clk_div.sv | 39 +++
 rtl/spi_xfer_ctrl.sv | 123 ++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master transfer sequencer:
// FSM state encoding, bits per SPI word and the default divider.
package spi_pkg;

  localparam int SPI_BITS    = 8;
  localparam int CLK_DIV_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_STORE  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK generator: toggles sclk every CLK_DIV enabled cycles and flags the
// cycle in which a rising or falling SCLK edge is being produced.
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] cnt;
  logic          tc;

  assign tc   = en && (cnt == DW'(CLK_DIV - 1));
  assign rise = tc && !sclk;
  assign fall = tc && sclk;

  // Dropping en parks the divider at zero with sclk low, so every byte starts aligned.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tc) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 master sequencer: pops TX FIFO bytes, shifts them out MSB-first,
// captures MISO bytes into the RX FIFO, for a programmed byte count.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] byte_cnt,
  output logic             busy,
  output logic             done,
  input  logic             tx_empty,
  input  logic [7:0]       tx_dout,
  output logic             tx_rde,
  input  logic             rx_full,
  output logic [7:0]       rx_din,
  output logic             rx_wre,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             cs_n
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remaining;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_shift;
  logic [7:0]       rx_shift;
  logic             div_en, sck_rise, sck_fall, last_bit;
  logic             load_fire, store_fire;

  // Abort silences the divider in the same cycle so sclk returns low with FINISH.
  assign div_en   = (state == ST_SHIFT) && !abort;
  assign last_bit = sck_fall && (bit_cnt == 3'(SPI_BITS - 1));

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk  (clk),
    .rstn (rstn),
    .en   (div_en),
    .sclk (sclk),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_fire  = 1'b0;
    store_fire = 1'b0;
    case (state)
      ST_IDLE:   if (start && (byte_cnt != '0)) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (abort) begin
          state_nxt = ST_FINISH;
        end else if (!tx_empty) begin
          load_fire = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort)         state_nxt = ST_FINISH;
        else if (last_bit) state_nxt = ST_STORE;
      end
      ST_STORE: begin
        if (abort) begin
          state_nxt = ST_FINISH;
        end else if (!rx_full) begin
          store_fire = 1'b1;
          state_nxt  = (remaining == CNT_W'(1)) ? ST_FINISH : ST_LOAD;
        end
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      remaining <= '0;
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      mosi      <= 1'b0;
      tx_rde    <= 1'b0;
      rx_wre    <= 1'b0;
      rx_din    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cs_n      <= 1'b1;
    end else begin
      tx_rde <= load_fire;
      rx_wre <= store_fire;
      busy   <= (state_nxt != ST_IDLE);
      cs_n   <= (state_nxt == ST_IDLE);
      done   <= (state_nxt == ST_FINISH);
      if ((state == ST_IDLE) && (state_nxt == ST_LOAD)) remaining <= byte_cnt;
      if (load_fire) begin
        tx_shift <= tx_dout;
        mosi     <= tx_dout[7];
        bit_cnt  <= '0;
      end else if (sck_fall) begin
        bit_cnt  <= bit_cnt + 3'd1;
        tx_shift <= {tx_shift[6:0], 1'b0};
        mosi     <= tx_shift[6];
      end
      if (sck_rise) rx_shift <= {rx_shift[6:0], miso};
      if (store_fire) begin
        rx_din    <= rx_shift;
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: FIFO models and an SPI slave model around the DUT,
// directed scenarios followed by randomized transactions with FIFO stalls.
module tb_spi_xfer_ctrl;

  localparam int CD = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] byte_cnt = '0;
  logic          busy, done, tx_empty, tx_rde, rx_full, rx_wre, sclk, mosi, cs_n;
  logic          miso = 1'b0;
  logic [7:0]    tx_dout, rx_din;

  logic [7:0] tx_mem [256];
  logic [7:0] wp = 8'd0;
  logic [7:0] rp = 8'd0;
  logic tx_block = 1'b0, rx_hold = 1'b0, rs_tx = 1'b0, rs_rx = 1'b0, rand_stall = 1'b0;
  int   mode = 1;  // 0: random slave bits, 1: loopback, 2: constant one

  assign tx_empty = (rp == wp) || tx_block || rs_tx;
  assign tx_dout  = tx_mem[rp];
  assign rx_full  = rx_hold || rs_rx;

  int busy_cyc = 0, done_cnt = 0, rde_cnt = 0, wre_cnt = 0, rise_cnt = 0;
  int cs_viol = 0, rde_viol = 0, wre_viol = 0;
  logic [7:0] rx_got[$], slave_got[$], sent_miso[$];
  logic [7:0] sh_mo = 8'd0, sh_mi = 8'd0;
  int   sbit = 0;
  logic sclk_q = 1'b0;

  int n_cmp = 0, n_mis = 0;
  int s_rx, s_sl, s_done, s_rde, s_wre, s_rise;

  spi_xfer_ctrl #(.CLK_DIV(CD), .CNT_W(CW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .abort    (abort),
    .byte_cnt (byte_cnt),
    .busy     (busy),
    .done     (done),
    .tx_empty (tx_empty),
    .tx_dout  (tx_dout),
    .tx_rde   (tx_rde),
    .rx_full  (rx_full),
    .rx_din   (rx_din),
    .rx_wre   (rx_wre),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .cs_n     (cs_n)
  );

  always #5 clk = ~clk;

  // FIFO models, SPI slave and event counters, all sampled on the falling clock edge.
  always @(negedge clk) begin
    sclk_q <= sclk;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (cs_n !== !busy) cs_viol <= cs_viol + 1;
    if (tx_rde) begin
      rde_cnt <= rde_cnt + 1;
      rp      <= rp + 8'd1;
      if (tx_empty) rde_viol <= rde_viol + 1;
    end
    if (rx_wre) begin
      wre_cnt <= wre_cnt + 1;
      rx_got.push_back(rx_din);
      if (rx_full) wre_viol <= wre_viol + 1;
    end
    if (cs_n) begin
      sbit <= 0;
    end else if (sclk && !sclk_q) begin
      rise_cnt <= rise_cnt + 1;
      sh_mo    <= {sh_mo[6:0], mosi};
      sh_mi    <= {sh_mi[6:0], miso};
      if (sbit == 7) begin
        slave_got.push_back({sh_mo[6:0], mosi});
        sent_miso.push_back({sh_mi[6:0], miso});
        sbit <= 0;
      end else begin
        sbit <= sbit + 1;
      end
    end
    case (mode)
      1:       miso <= mosi;
      2:       miso <= 1'b1;
      default: if (!sclk) miso <= 1'($urandom_range(0, 1));
    endcase
    if (!tx_rde) rs_tx <= rand_stall && ($urandom_range(0, 2) == 0);
    if (!rx_wre) rs_rx <= rand_stall && ($urandom_range(0, 2) == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    tx_mem[wp] = b;
    wp = wp + 8'd1;
  endtask

  task automatic go(input int cnt);
    byte_cnt = CW'(cnt);
    start    = 1'b1;
    step(1);
    start    = 1'b0;
  endtask

  task automatic snap();
    s_rx   = rx_got.size();
    s_sl   = slave_got.size();
    s_done = done_cnt;
    s_rde  = rde_cnt;
    s_wre  = wre_cnt;
    s_rise = rise_cnt;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int k;
    k = 0;
    while (!done && k < lim) begin
      step(1);
      k++;
    end
    chk({tag, "_done"}, done, 1'b1);
    step(1);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_csn"}, cs_n, 1'b1);
  endtask

  task automatic wait_rises(input string tag, input int n);
    int k;
    k = 0;
    while ((rise_cnt - s_rise) < n && k < 300) begin
      step(1);
      k++;
    end
    chk({tag, "_rise_wait"}, 32'((rise_cnt - s_rise) >= n), 1);
  endtask

  // Slave must have seen the pushed bytes; RX FIFO must hold what the slave sent.
  task automatic cmp_bytes(input string tag, input logic [7:0] exp_tx[$]);
    chk({tag, "_nslave"}, slave_got.size() - s_sl, exp_tx.size());
    chk({tag, "_nrx"}, rx_got.size() - s_rx, exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++) begin
      if (s_sl + i < slave_got.size())
        chk($sformatf("%s_mosi%0d", tag, i), slave_got[s_sl + i], exp_tx[i]);
      if (s_rx + i < rx_got.size() && s_sl + i < sent_miso.size())
        chk($sformatf("%s_miso%0d", tag, i), rx_got[s_rx + i], sent_miso[s_sl + i]);
    end
  endtask

  initial begin
    logic [7:0] exp_tx[$];
    logic [7:0] b;
    int n;
    for (int i = 0; i < 256; i++) tx_mem[i] = 8'h00;

    step(3);
    chk("rst_csn", cs_n, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_txrde", tx_rde, 1'b0);
    chk("rst_rxwre", rx_wre, 1'b0);
    chk("rst_rxdin", rx_din, 8'h00);
    rstn = 1'b1;
    step(2);

    // Loopback of two bytes, no stalls
    mode = 1;
    snap();
    push(8'hA5);
    push(8'h3C);
    go(2);
    chk("t1_busy", busy, 1'b1);
    chk("t1_csn", cs_n, 1'b0);
    begin
      int bc0;
      bc0 = busy_cyc;
      wait_done("t1", 200);
      chk("t1_busy_cycles", busy_cyc - bc0, 2 * (2 + 16 * CD) + 1);
    end
    chk("t1_nrx", rx_got.size() - s_rx, 2);
    if (rx_got.size() >= s_rx + 2) begin
      chk("t1_rx0", rx_got[s_rx], 8'hA5);
      chk("t1_rx1", rx_got[s_rx + 1], 8'h3C);
    end
    chk("t1_rises", rise_cnt - s_rise, 16);
    chk("t1_rde", rde_cnt - s_rde, 2);
    chk("t1_wre", wre_cnt - s_wre, 2);
    chk("t1_done_cnt", done_cnt - s_done, 1);

    // TX FIFO empty: stall in LOAD, then supply 0x81 with miso tied high
    mode = 2;
    tx_block = 1'b1;
    snap();
    go(1);
    step(20);
    chk("t2_busy", busy, 1'b1);
    chk("t2_csn", cs_n, 1'b0);
    chk("t2_sclk", sclk, 1'b0);
    chk("t2_no_rde", rde_cnt - s_rde, 0);
    push(8'h81);
    tx_block = 1'b0;
    wait_done("t2", 200);
    chk("t2_nrx", rx_got.size() - s_rx, 1);
    if (rx_got.size() > s_rx) chk("t2_rx", rx_got[s_rx], 8'hFF);
    if (slave_got.size() > s_sl) chk("t2_mosi", slave_got[s_sl], 8'h81);

    // RX FIFO full during STORE, three bytes, order preserved
    mode = 0;
    rx_hold = 1'b1;
    snap();
    exp_tx.delete();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      exp_tx.push_back(b);
      push(b);
    end
    go(3);
    wait_rises("t3", 8);
    step(12);
    chk("t3_no_wre_full", wre_cnt - s_wre, 0);
    chk("t3_busy_stall", busy, 1'b1);
    rx_hold = 1'b0;
    wait_done("t3", 400);
    chk("t3_wre", wre_cnt - s_wre, 3);
    cmp_bytes("t3", exp_tx);

    // Abort after the third rising SCLK edge of the first byte
    snap();
    push(8'($urandom));
    go(2);
    wait_rises("t4", 3);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t4_done", done, 1'b1);
    chk("t4_sclk", sclk, 1'b0);
    chk("t4_csn_low", cs_n, 1'b0);
    step(1);
    chk("t4_done_off", done, 1'b0);
    chk("t4_csn_high", cs_n, 1'b1);
    chk("t4_busy", busy, 1'b0);
    chk("t4_no_wre", wre_cnt - s_wre, 0);
    chk("t4_rde", rde_cnt - s_rde, 1);
    chk("t4_done_cnt", done_cnt - s_done, 1);

    // Zero-length start is ignored; start while busy is ignored
    snap();
    go(0);
    step(3);
    chk("t5_zero_busy", busy, 1'b0);
    chk("t5_zero_csn", cs_n, 1'b1);
    chk("t5_zero_done", done_cnt - s_done, 0);
    snap();
    push(8'($urandom));
    push(8'($urandom));
    go(2);
    step(5);
    byte_cnt = CW'(5);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done("t5", 300);
    chk("t5_rde", rde_cnt - s_rde, 2);
    chk("t5_wre", wre_cnt - s_wre, 2);
    chk("t5_done_cnt", done_cnt - s_done, 1);

    // Asynchronous reset in the middle of SHIFT
    snap();
    push(8'($urandom));
    go(1);
    wait_rises("t6", 2);
    rstn = 1'b0;
    #1;
    chk("t6_csn", cs_n, 1'b1);
    chk("t6_sclk", sclk, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_rxwre", rx_wre, 1'b0);
    step(2);
    rstn = 1'b1;
    step(1);
    snap();
    exp_tx.delete();
    b = 8'($urandom);
    exp_tx.push_back(b);
    push(b);
    go(1);
    wait_done("t6_after", 200);
    cmp_bytes("t6_after", exp_tx);

    // Randomized transactions with random FIFO back-pressure
    rand_stall = 1'b1;
    for (int t = 0; t < 5; t++) begin
      n = $urandom_range(1, 6);
      snap();
      exp_tx.delete();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_tx.push_back(b);
        push(b);
      end
      go(n);
      wait_done($sformatf("rnd%0d", t), n * 150 + 50);
      cmp_bytes($sformatf("rnd%0d", t), exp_tx);
      chk($sformatf("rnd%0d_done_cnt", t), done_cnt - s_done, 1);
    end
    rand_stall = 1'b0;
    step(2);

    chk("inv_csn_vs_busy", cs_viol, 0);
    chk("inv_rde_when_empty", rde_viol, 0);
    chk("inv_wre_when_full", wre_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
